// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic-light monitor: light codes, tracking
// modes and the default phase lengths of the nominal controller.
package traffic_light_monitor_pkg;

   typedef enum logic [1:0] {
      L_OFF    = 2'd0,
      L_GREEN  = 2'd1,
      L_YELLOW = 2'd2,
      L_RED    = 2'd3
   } light_t;

   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_GREEN  = 2'd1,
      M_YELLOW = 2'd2,
      M_RED    = 2'd3
   } mode_t;

   localparam int DEF_GREEN_LEN  = 25;
   localparam int DEF_YELLOW_LEN = 3;
   localparam int DEF_RED_LEN    = 14;
   localparam int DEF_CNT_W      = 6;

endpackage

// File: rtl/traffic_light_monitor_phase_timer.sv
// Registers the incoming light code, flags a code change and counts how long
// the current code has been held (saturating).
module traffic_light_monitor_phase_timer
   import traffic_light_monitor_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       state_in,
   output logic             change,
   output logic [CNT_W-1:0] run
);

   logic [1:0] state_q;

   assign change = (state_in != state_q);

   // The first sample of a new code counts as 1, so run equals the phase
   // length once the last sample of that phase has been taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= L_OFF;
         run     <= '0;
      end else begin
         state_q <= state_in;
         if (change) begin
            run <= CNT_W'(1);
         end else if (run != {CNT_W{1'b1}}) begin
            run <= run + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Consumer-side checker of the light controller: tracks G->Y->R, checks phase
// lengths, keeps sticky fault flags and drives the pedestrian walk signal.
module traffic_light_monitor
   import traffic_light_monitor_pkg::*;
#(
   parameter int GREEN_LEN  = DEF_GREEN_LEN,
   parameter int YELLOW_LEN = DEF_YELLOW_LEN,
   parameter int RED_LEN    = DEF_RED_LEN,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       state_in,
   input  logic             clr_err,
   output logic             walk,
   output logic [CNT_W-1:0] walk_countdown,
   output logic [CNT_W-1:0] phase_len,
   output logic             err_seq,
   output logic             err_len,
   output logic             locked
);

   localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_LEN);
   localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_LEN);
   localparam logic [CNT_W-1:0] RED_L    = CNT_W'(RED_LEN);

   function automatic logic [CNT_W-1:0] len_of(input mode_t m);
      case (m)
         M_GREEN:  len_of = GREEN_L;
         M_YELLOW: len_of = YELLOW_L;
         M_RED:    len_of = RED_L;
         default:  len_of = '0;
      endcase
   endfunction

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         M_GREEN:  next_mode = M_YELLOW;
         M_YELLOW: next_mode = M_RED;
         M_RED:    next_mode = M_GREEN;
         default:  next_mode = M_IDLE;
      endcase
   endfunction

   function automatic logic [1:0] next_code(input mode_t m);
      case (m)
         M_GREEN:  next_code = L_YELLOW;
         M_YELLOW: next_code = L_RED;
         M_RED:    next_code = L_GREEN;
         default:  next_code = L_GREEN;
      endcase
   endfunction

   logic             change;
   logic [CNT_W-1:0] run;

   traffic_light_monitor_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .state_in (state_in),
      .change   (change),
      .run      (run)
   );

   mode_t            mode_q, mode_d;
   logic             clean_q, clean_d;
   logic             locked_q, locked_d;
   logic             err_seq_q, err_seq_d;
   logic             err_len_q, err_len_d;
   logic [CNT_W-1:0] phase_len_q, phase_len_d;
   logic             seq_evt, len_evt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q      <= M_IDLE;
         clean_q     <= 1'b0;
         locked_q    <= 1'b0;
         err_seq_q   <= 1'b0;
         err_len_q   <= 1'b0;
         phase_len_q <= '0;
      end else begin
         mode_q      <= mode_d;
         clean_q     <= clean_d;
         locked_q    <= locked_d;
         err_seq_q   <= err_seq_d;
         err_len_q   <= err_len_d;
         phase_len_q <= phase_len_d;
      end
   end

   always_comb begin
      mode_d      = mode_q;
      clean_d     = clean_q;
      locked_d    = locked_q;
      phase_len_d = phase_len_q;
      seq_evt     = 1'b0;
      len_evt     = 1'b0;

      if (mode_q == M_IDLE) begin
         // Tracking only starts on a fresh green entry, whose length is unknown.
         if (change && (state_in == L_GREEN)) begin
            mode_d  = M_GREEN;
            clean_d = 1'b1;
         end
      end else if (change) begin
         phase_len_d = run;
         if (state_in == next_code(mode_q)) begin
            if (run != len_of(mode_q)) begin
               len_evt = 1'b1;
               clean_d = 1'b0;
            end
            if ((mode_q == M_RED) && clean_q && (run == RED_L)) begin
               locked_d = 1'b1;
            end
            mode_d = next_mode(mode_q);
         end else begin
            seq_evt  = 1'b1;
            clean_d  = 1'b0;
            locked_d = 1'b0;
            mode_d   = M_IDLE;
         end
      end else if (run == len_of(mode_q)) begin
         // Phase held past its length: flag now rather than waiting for the exit.
         len_evt = 1'b1;
         clean_d = 1'b0;
      end

      err_seq_d = seq_evt | (err_seq_q & ~clr_err);
      err_len_d = len_evt | (err_len_q & ~clr_err);
   end

   assign walk           = locked_q && (mode_q == M_RED);
   assign walk_countdown = !walk ? '0 :
                           (run > RED_L) ? '0 : (RED_L - run);
   assign phase_len      = phase_len_q;
   assign err_seq        = err_seq_q;
   assign err_len        = err_len_q;
   assign locked         = locked_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: nominal cycling, length and
// sequence faults, overrun, error clearing and reset during walk.
module tb_traffic_light_monitor;

   localparam int CNT_W = 6;
   localparam logic [1:0] C_OFF = 2'd0, C_G = 2'd1, C_Y = 2'd2, C_R = 2'd3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [1:0]       state_in = C_OFF;
   logic             clr_err = 1'b0;
   logic             walk;
   logic [CNT_W-1:0] walk_countdown;
   logic [CNT_W-1:0] phase_len;
   logic             err_seq, err_len, locked;

   int total = 0;
   int bad   = 0;

   traffic_light_monitor #(
      .GREEN_LEN  (25),
      .YELLOW_LEN (3),
      .RED_LEN    (14),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .state_in       (state_in),
      .clr_err        (clr_err),
      .walk           (walk),
      .walk_countdown (walk_countdown),
      .phase_len      (phase_len),
      .err_seq        (err_seq),
      .err_len        (err_len),
      .locked         (locked)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // one sample of code c, outputs settled 1ns after the edge
   task automatic cyc(input logic [1:0] c);
      state_in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [1:0] c, input int n);
      for (int k = 0; k < n; k++) cyc(c);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      clr_err  = 1'b0;
      state_in = C_OFF;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (walk !== 1'b0) begin bad++; $display("FAIL reset_walk got=%0d exp=0", walk); end
      total++; if (walk_countdown !== '0) begin bad++; $display("FAIL reset_cd got=%0d exp=0", walk_countdown); end
      total++; if (phase_len !== '0) begin bad++; $display("FAIL reset_plen got=%0d exp=0", phase_len); end
      total++; if ({err_seq, err_len, locked} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {err_seq, err_len, locked}); end
   endtask

   task automatic test_nominal();
      do_reset();
      hold(C_G, 25);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL nom_lock_early got=%0d exp=0", locked); end
      cyc(C_Y);
      total++; if (phase_len !== 6'd25) begin bad++; $display("FAIL nom_plen_g got=%0d exp=25", phase_len); end
      hold(C_Y, 2);
      cyc(C_R);
      total++; if (phase_len !== 6'd3) begin bad++; $display("FAIL nom_plen_y got=%0d exp=3", phase_len); end
      hold(C_R, 13);
      total++; if (walk !== 1'b0) begin bad++; $display("FAIL nom_walk_unlocked got=%0d exp=0", walk); end
      cyc(C_G);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL nom_locked got=%0d exp=1", locked); end
      total++; if (phase_len !== 6'd14) begin bad++; $display("FAIL nom_plen_r got=%0d exp=14", phase_len); end
      hold(C_G, 24);
      hold(C_Y, 3);
      for (int i = 1; i <= 14; i++) begin
         cyc(C_R);
         total++; if (walk !== 1'b1) begin bad++; $display("FAIL nom_walk[%0d] got=%0d exp=1", i, walk); end
         total++; if (walk_countdown !== CNT_W'(14 - i)) begin bad++; $display("FAIL nom_cd[%0d] got=%0d exp=%0d", i, walk_countdown, 14 - i); end
      end
      cyc(C_G);
      total++; if (walk !== 1'b0) begin bad++; $display("FAIL nom_walk_fall got=%0d exp=0", walk); end
      total++; if (walk_countdown !== '0) begin bad++; $display("FAIL nom_cd_fall got=%0d exp=0", walk_countdown); end
      total++; if ({err_seq, err_len, locked} !== 3'b001) begin bad++; $display("FAIL nom_flags got=%b exp=001", {err_seq, err_len, locked}); end
   endtask

   task automatic test_short_yellow();
      do_reset();
      hold(C_G, 25);
      hold(C_Y, 2);
      cyc(C_R);
      total++; if (err_len !== 1'b1) begin bad++; $display("FAIL sy_err_len got=%0d exp=1", err_len); end
      total++; if (phase_len !== 6'd2) begin bad++; $display("FAIL sy_plen got=%0d exp=2", phase_len); end
      total++; if (err_seq !== 1'b0) begin bad++; $display("FAIL sy_err_seq got=%0d exp=0", err_seq); end
      hold(C_R, 13);
      cyc(C_G);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL sy_locked got=%0d exp=0", locked); end
      total++; if (phase_len !== 6'd14) begin bad++; $display("FAIL sy_plen_r got=%0d exp=14", phase_len); end
   endtask

   task automatic test_skip();
      do_reset();
      hold(C_G, 25);
      cyc(C_R);
      total++; if ({err_seq, err_len, locked, walk} !== 4'b1000) begin bad++; $display("FAIL skip_flags got=%b exp=1000", {err_seq, err_len, locked, walk}); end
      total++; if (phase_len !== 6'd25) begin bad++; $display("FAIL skip_plen got=%0d exp=25", phase_len); end
      hold(C_R, 13);
      total++; if (walk !== 1'b0) begin bad++; $display("FAIL skip_walk got=%0d exp=0", walk); end
      hold(C_G, 25);
      cyc(C_Y);
      total++; if (phase_len !== 6'd25) begin bad++; $display("FAIL skip_rec_plen got=%0d exp=25", phase_len); end
      hold(C_Y, 2);
      hold(C_R, 14);
      cyc(C_G);
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL skip_rec_locked got=%0d exp=1", locked); end
      total++; if (err_len !== 1'b0) begin bad++; $display("FAIL skip_rec_err_len got=%0d exp=0", err_len); end
   endtask

   task automatic test_overrun();
      do_reset();
      hold(C_G, 25);
      total++; if (err_len !== 1'b0) begin bad++; $display("FAIL ovr_early got=%0d exp=0", err_len); end
      cyc(C_G);
      total++; if (err_len !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0d exp=1", err_len); end
      hold(C_G, 14);
      total++; if ({err_seq, err_len} !== 2'b01) begin bad++; $display("FAIL ovr_end got=%b exp=01", {err_seq, err_len}); end
   endtask

   task automatic test_clr_err();
      do_reset();
      hold(C_G, 3);
      cyc(C_OFF);
      total++; if (err_seq !== 1'b1) begin bad++; $display("FAIL clr_seq_set got=%0d exp=1", err_seq); end
      clr_err = 1'b1;
      cyc(C_OFF);
      clr_err = 1'b0;
      total++; if ({err_seq, err_len} !== 2'b00) begin bad++; $display("FAIL clr_alone got=%b exp=00", {err_seq, err_len}); end
      hold(C_G, 3);
      clr_err = 1'b1;
      cyc(C_R);
      clr_err = 1'b0;
      total++; if (err_seq !== 1'b1) begin bad++; $display("FAIL clr_seq_wins got=%0d exp=1", err_seq); end
      hold(C_G, 4);
      clr_err = 1'b1;
      cyc(C_Y);
      total++; if ({err_seq, err_len} !== 2'b01) begin bad++; $display("FAIL clr_len_wins got=%b exp=01", {err_seq, err_len}); end
      cyc(C_Y);
      clr_err = 1'b0;
      total++; if ({err_seq, err_len} !== 2'b00) begin bad++; $display("FAIL clr_both got=%b exp=00", {err_seq, err_len}); end
   endtask

   task automatic test_reset_mid_red();
      do_reset();
      hold(C_G, 25); hold(C_Y, 3); hold(C_R, 14);
      hold(C_G, 25); hold(C_Y, 3); hold(C_R, 5);
      total++; if ({walk, walk_countdown} !== {1'b1, 6'd9}) begin bad++; $display("FAIL mr_walk got=%0d/%0d exp=1/9", walk, walk_countdown); end
      #1;
      reset = 1'b1;
      #1;
      total++; if ({walk, walk_countdown, phase_len} !== '0) begin bad++; $display("FAIL mr_async_out got=%0d/%0d/%0d exp=0/0/0", walk, walk_countdown, phase_len); end
      total++; if ({err_seq, err_len, locked} !== 3'b000) begin bad++; $display("FAIL mr_async_flags got=%b exp=000", {err_seq, err_len, locked}); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      hold(C_R, 4);
      hold(C_G, 25);
      cyc(C_Y);
      total++; if (phase_len !== 6'd25) begin bad++; $display("FAIL mr_restart_plen got=%0d exp=25", phase_len); end
      total++; if ({err_seq, err_len, locked} !== 3'b000) begin bad++; $display("FAIL mr_restart_flags got=%b exp=000", {err_seq, err_len, locked}); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short_yellow();
      test_skip();
      test_overrun();
      test_clr_err();
      test_reset_mid_red();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Checker and pedestrian-signal driver sitting on the consumer side of the traffic-light controller's 2-bit light-state output. It samples the light code, tracks the expected green→yellow→red sequence with its own FSM, and measures each phase length against configured durations. It flags sequence and duration faults with sticky flags, and drives a pedestrian walk signal plus a countdown during red once the sequence is locked.

## Interface
- GREEN_LEN, 25, required green phase length in clk cycles
- YELLOW_LEN, 3, required yellow phase length
- RED_LEN, 14, required red phase length
- CNT_W, 6, width of run/phase/countdown counters; all *_LEN < 2^CNT_W
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- state_in  input  2  light code from controller: 0 OFF, 1 GREEN, 2 YELLOW, 3 RED
- clr_err  input  1  one-cycle pulse, clears err_seq/err_len
- walk  output  1  pedestrian walk, high during validated red
- walk_countdown  output  CNT_W  cycles of red remaining while walk=1, else 0
- phase_len  output  CNT_W  measured length of last completed phase
- err_seq  output  1  sticky: illegal transition or OFF seen while tracking
- err_len  output  1  sticky: phase length ≠ configured length
- locked  output  1  one full clean G/Y/R cycle validated since last error/reset

## Operation
- state_q: registered copy of state_in, reset 0 (OFF). change = (state_in ≠ state_q).
- run: on change → 1; else run+1, saturating at 2^CNT_W−1. Reset 0.
- Mode FSM: M_IDLE, M_GREEN, M_YELLOW, M_RED; reset M_IDLE.
- M_IDLE: ignore all codes until change with state_in=GREEN → M_GREEN. No length check on that entry. Set clean=1.
- Legal edges: GREEN→YELLOW, YELLOW→RED, RED→GREEN. At a legal change: phase_len ← run; if run ≠ LEN of the exiting mode → err_len=1, clean=0; advance mode.
- Any other change while not M_IDLE (including to OFF, or a skipped phase): err_seq=1, clean=0, locked=0, mode → M_IDLE, phase_len ← run.
- Overrun: no change, mode ≠ M_IDLE, run == LEN of current mode → err_len=1, clean=0 on that edge. The later exit check re-flags; this is harmless.
- locked: set at a legal RED→GREEN change when clean=1 and that red passed its length check. Cleared by reset or any err_seq event. An err_len event clears clean but not locked; locked stays low until the next clean cycle if it was already low.
- walk = locked & (mode == M_RED). walk_countdown = walk ? RED_LEN − run : 0, floored at 0 if run > RED_LEN.
- clr_err clears both error flags. A new error in the same cycle wins (flag stays 1).
- Reset mid-phase: all state returns to reset values immediately. Tracking restarts from the next GREEN entry.

## Timing
- Reset values: walk 0, walk_countdown 0, phase_len 0, err_seq 0, err_len 0, locked 0.
- All outputs derive from registers only. There is no combinational path from state_in.
- Input-to-flag latency: a fault sampled at edge n shows on the flag after edge n.
- walk rises 1 cycle after state_in goes RED (the mode update edge), with countdown RED_LEN−1. It falls the cycle after state_in leaves RED.
- Nominal controller period (25/3/14) yields phase_len sequence 25, 3, 14 with no errors. locked rises at the first RED→GREEN edge after one full cycle, i.e. 42 cycles after first GREEN entry.

## Structure
- Shared package: light codes (OFF/GREEN/YELLOW/RED, 2-bit), mode enum, default phase lengths.
- One natural sub-module: phase_timer (change detect, state_q register, saturating run counter). The FSM, checks and outputs live in the top.

## Test plan
- Nominal: drive 25 G / 3 Y / 14 R repeating from reset → no errors; phase_len 25, 3, 14; locked=1 from cycle 43; walk high 14 cycles per red, countdown 13→0.
- Short yellow: G25, Y2, R14 → err_len=1 after the Y→R edge, phase_len=2; locked stays 0 for that cycle.
- Skip: G25 then R directly → err_seq=1, mode M_IDLE, locked=0, walk=0; recovery needs a fresh GREEN entry.
- Overrun: hold GREEN 40 cycles → err_len=1 on the edge where run reaches 25; no err_seq.
- clr_err pulsed in the same cycle as a new violation → flag remains 1; pulsed alone → both flags 0 next cycle.
- Reset asserted mid-red with walk=1 → all outputs 0 immediately; after release, the first GREEN entry restarts tracking with no spurious flags.
